opb_region_decoder: RTL
=======================

OPB_REGION_DECODER -- requirements
Module: opb_region_decoder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_SLV, 4, number of slave regions (1..32)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- REGION_BASE, {0x400,0x300,0x200,0x100}, packed N_SLV*ADDR_W region base addresses, region 0 in the LSBs
- REGION_SIZE, {4{0x10}}, packed N_SLV*ADDR_W region sizes in addresses; a size of 0 disables that region
- FIXED_LAT, 4'b0001, per-region flag; 1 = legacy slave that implicitly acks one cycle after RE
- TIMEOUT_CYC, 16, maximum read-wait cycles
- ERR_DATA, 0xDEADBEEF, read data returned on error
REQ-002 Ports SHALL be (name, direction, width, meaning):
- OPB_CLK, in, 1, sole clock
- OPB_RST_N, in, 1, reset, asynchronous, active-low
- DEC_RE, in, 1, read strobe
- DEC_WE, in, 1, write strobe
- DEC_ADDR, in, ADDR_W, access address
- DEC_DO, out, DATA_W, registered read data
- DEC_ACK, out, 1, one-cycle transfer-complete pulse
- DEC_ERR, out, 1, one-cycle error pulse, always coincident with DEC_ACK
- SLV_RE, out, N_SLV, one-hot per-slave read strobe
- SLV_WE, out, N_SLV, one-hot per-slave write strobe
- SLV_DI, in, N_SLV*DATA_W, packed slave read data
- SLV_ACK, in, N_SLV, per-slave read acknowledge
- ERR_CLR, in, 1, clears the error counter
- ERR_ADDR, out, ADDR_W, address of the most recent error
- ERR_CNT, out, 8, saturating error count
- BUSY, out, 1, high whenever the FSM is not in IDLE

Function
REQ-003 Region k SHALL hit when REGION_BASE[k] <= DEC_ADDR < REGION_BASE[k]+REGION_SIZE[k], with the sum computed at ADDR_W+1 bits so that it cannot wrap.
REQ-004 When regions overlap, the lowest-index region SHALL win, so SLV_RE and SLV_WE are never multi-hot.
REQ-005 The FSM SHALL have exactly three states: IDLE, RD_WAIT and RESP.
REQ-006 Strobes SHALL be accepted only in IDLE.
REQ-007 SLV_RE and SLV_WE SHALL be combinational from strobe, hit and (state==IDLE), and SHALL last exactly one cycle.
REQ-008 If DEC_RE and DEC_WE are asserted together, the access SHALL be treated as a write only; no SLV_RE is issued.
REQ-009 A write to a mapped region SHALL pulse SLV_WE[k] and go IDLE->RESP; DEC_ACK follows 1 cycle after the strobe, with DEC_ERR=0.
REQ-010 A read to a mapped region SHALL pulse SLV_RE[k], latch sel=k and the address, and go IDLE->RD_WAIT.
REQ-011 In RD_WAIT, SLV_ACK[sel] (or FIXED_LAT[sel]=1 on the first RD_WAIT cycle) SHALL register DEC_DO<=SLV_DI[sel] and go to RESP; the minimum read latency is DEC_ACK 2 cycles after the strobe.
REQ-012 SLV_ACK from non-selected slaves SHALL be ignored, as SHALL SLV_ACK received outside RD_WAIT.
REQ-013 The timeout counter SHALL clear on entry to RD_WAIT and increment each RD_WAIT cycle; at TIMEOUT_CYC RD_WAIT cycles without ack it SHALL load DEC_DO=ERR_DATA, flag an error and go to RESP.
REQ-014 An ack arriving in the same cycle the timeout expires SHALL win: no error is flagged.
REQ-015 An unmapped read or write SHALL go IDLE->RESP with an error flagged; no slave strobe is issued.
REQ-016 RESP SHALL pulse DEC_ACK, and DEC_ERR if an error is flagged, for one cycle, then return to IDLE; DEC_DO SHALL be 0 in every cycle except the RESP cycle of a read.
REQ-017 A strobe arriving while BUSY=1 SHALL be dropped: no slave strobe, no DEC_ACK, ERR_CNT increments, ERR_ADDR unchanged.
REQ-018 Each error SHALL load ERR_ADDR with the access address and increment ERR_CNT, which saturates at 255.
REQ-019 ERR_CLR SHALL zero ERR_CNT; when ERR_CLR coincides with an error, ERR_CNT SHALL become 1.
REQ-020 A new strobe presented in the RESP cycle SHALL be dropped per REQ-017; it is accepted from the following IDLE cycle.

Reset
REQ-021 When OPB_RST_N=0, the state SHALL go to IDLE immediately.
REQ-022 When OPB_RST_N=0, DEC_DO, DEC_ACK, DEC_ERR, ERR_ADDR, ERR_CNT, BUSY and the timeout counter SHALL be 0.
REQ-023 SLV_RE and SLV_WE SHALL be 0 while OPB_RST_N=0.
REQ-024 A reset during RD_WAIT SHALL abort the read with no DEC_ACK, and a late SLV_ACK after reset SHALL be ignored.

Verification (default parameters)
REQ-025 Legacy-latency read: read 0x105 with SLV_DI[0]=0x12345678 -> SLV_RE=0001 at c0, then DEC_ACK=1 and DEC_DO=0x12345678 at c2.
REQ-026 Handshake read and boundary miss: read 0x20F with SLV_ACK[1] at c5 -> DEC_ACK at c6; then read 0x210 -> no strobe, DEC_ACK and DEC_ERR 1 cycle later, ERR_ADDR=0x210.
REQ-027 Timeout: read 0x300 with no ack -> at c17 DEC_ACK=DEC_ERR=1, DEC_DO=0xDEADBEEF, ERR_CNT increments; an ack injected at c16 instead -> no error.
REQ-028 Simultaneous strobes: DEC_RE and DEC_WE at 0x400 -> SLV_WE=1000, SLV_RE=0000, DEC_ACK at c1, DEC_ERR=0.
REQ-029 Busy drop and counter: strobe at 0x100 during RD_WAIT -> no SLV_RE, ERR_CNT+1; 300 unmapped accesses -> ERR_CNT=255; ERR_CLR with a coincident error -> ERR_CNT=1.
REQ-030 Reset mid-read: OPB_RST_N low in RD_WAIT -> all outputs 0, BUSY=0; after release, read 0x105 completes per REQ-025.

Source files
------------

// File: rtl/opb_region_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : opb_region_decoder
//  Brief    : OPB address-region decoder with read-wait FSM, timeout and
//             error capture (sticky address + saturating counter).
//  Revision : 1.0 - initial release
// ============================================================================
module opb_region_decoder #(
    parameter int                        N_SLV       = 4,
    parameter int                        ADDR_W      = 32,
    parameter int                        DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   REGION_BASE = {32'h400, 32'h300, 32'h200, 32'h100},
    parameter logic [N_SLV*ADDR_W-1:0]   REGION_SIZE = {4{32'h10}},
    parameter logic [N_SLV-1:0]          FIXED_LAT   = 4'b0001,
    parameter int                        TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0]         ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                       OPB_CLK,
    input  logic                       OPB_RST_N,
    input  logic                       DEC_RE,
    input  logic                       DEC_WE,
    input  logic [ADDR_W-1:0]          DEC_ADDR,
    output logic [DATA_W-1:0]          DEC_DO,
    output logic                       DEC_ACK,
    output logic                       DEC_ERR,
    output logic [N_SLV-1:0]           SLV_RE,
    output logic [N_SLV-1:0]           SLV_WE,
    input  logic [N_SLV*DATA_W-1:0]    SLV_DI,
    input  logic [N_SLV-1:0]           SLV_ACK,
    input  logic                       ERR_CLR,
    output logic [ADDR_W-1:0]          ERR_ADDR,
    output logic [7:0]                 ERR_CNT,
    output logic                       BUSY
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam int                c_SEL_W   = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]          r_state;
    logic [c_SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_err;
    logic [DATA_W-1:0]   r_do;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [7:0]          r_err_cnt;

    logic [N_SLV-1:0]    w_hit;
    logic [N_SLV-1:0]    w_onehot;
    logic [c_SEL_W-1:0]  w_sel;
    logic                w_any_hit;
    logic                w_idle;
    logic                w_strobe;
    logic                w_accept;
    logic                w_drop;
    logic                w_unmapped;
    logic                w_rd_ack;
    logic                w_timeout;
    logic [1:0]          w_err_inc;
    logic [8:0]          w_cnt_sum;

    // End address is formed one bit wider so a region touching the top of
    // the address space cannot wrap around to zero.
    generate
        for (genvar k = 0; k < N_SLV; k++) begin : g_region
            logic [ADDR_W-1:0] w_base;
            logic [ADDR_W-1:0] w_size;
            logic [ADDR_W:0]   w_end;
            assign w_base   = REGION_BASE[k*ADDR_W +: ADDR_W];
            assign w_size   = REGION_SIZE[k*ADDR_W +: ADDR_W];
            assign w_end    = {1'b0, w_base} + {1'b0, w_size};
            assign w_hit[k] = (w_size != '0) && (DEC_ADDR >= w_base) &&
                              ({1'b0, DEC_ADDR} < w_end);
        end
    endgenerate

    // Descending scan leaves the lowest-index hit as the winner.
    always_comb begin
        w_any_hit = 1'b0;
        w_sel     = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_any_hit = 1'b1;
                w_sel     = c_SEL_W'(k);
            end
        end
        w_onehot = '0;
        if (w_any_hit) begin
            w_onehot[w_sel] = 1'b1;
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign w_strobe   = DEC_RE | DEC_WE;
    assign w_accept   = w_idle & w_strobe;
    assign w_drop     = ~w_idle & w_strobe;
    assign w_unmapped = w_accept & ~w_any_hit;

    assign SLV_WE = (OPB_RST_N && w_accept && DEC_WE) ? w_onehot : '0;
    assign SLV_RE = (OPB_RST_N && w_accept && DEC_RE && !DEC_WE) ? w_onehot : '0;

    assign w_rd_ack  = SLV_ACK[r_sel] | (FIXED_LAT[r_sel] & (r_to_cnt == '0));
    assign w_timeout = (r_state == S_RD_WAIT) & ~w_rd_ack & (r_to_cnt == c_TO_LAST);
    assign w_err_inc = {1'b0, w_unmapped | w_timeout} + {1'b0, w_drop};
    assign w_cnt_sum = {1'b0, r_err_cnt} + {7'b0, w_err_inc};

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_addr   <= '0;
            r_to_cnt <= '0;
            r_err    <= 1'b0;
            r_do     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_addr   <= DEC_ADDR;
                        r_sel    <= w_sel;
                        r_to_cnt <= '0;
                        if (!w_any_hit) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                            if (!DEC_WE) begin
                                r_do <= ERR_DATA;
                            end
                        end else if (DEC_WE) begin
                            r_err   <= 1'b0;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (w_rd_ack) begin
                        r_do    <= SLV_DI[r_sel*DATA_W +: DATA_W];
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_do    <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_do    <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Dropped strobes count as errors but keep the last captured address.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_unmapped) begin
                r_err_addr <= DEC_ADDR;
            end else if (w_timeout) begin
                r_err_addr <= r_addr;
            end
            if (ERR_CLR) begin
                r_err_cnt <= {6'b0, w_err_inc};
            end else if (w_cnt_sum[8]) begin
                r_err_cnt <= 8'hFF;
            end else begin
                r_err_cnt <= w_cnt_sum[7:0];
            end
        end
    end

    assign DEC_DO   = r_do;
    assign DEC_ACK  = (r_state == S_RESP);
    assign DEC_ERR  = DEC_ACK & r_err;
    assign BUSY     = (r_state != S_IDLE);
    assign ERR_ADDR = r_err_addr;
    assign ERR_CNT  = r_err_cnt;

endmodule
`default_nettype wire
